// File: rtl/rnbip_pkg.sv
// Shared types, state encoding and opcode class patterns for the RNBIP
// issue front end.
package rnbip_pkg;

  typedef enum logic [1:0] {
    ST_OPC    = 2'd0,
    ST_OPD    = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_BUBBLE = 2'd3
  } state_t;

  localparam logic [7:0] NOP_OPC = 8'h00;

  typedef struct packed {
    logic is_two_byte;
    logic is_ctrl;
    logic is_memrd;
  } opc_class_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] od;
    logic       valid;
  } issue_t;

  localparam issue_t ISSUE_NONE = '{opcode: NOP_OPC, od: NOP_OPC, valid: 1'b0};

  // An opcode matches a pattern when (opcode & mask) == value.
  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] value;
  } opc_pat_t;

  localparam opc_pat_t TWO_03   = '{mask: 8'hFF, value: 8'h03};
  localparam opc_pat_t TWO_05   = '{mask: 8'hFF, value: 8'h05};
  localparam opc_pat_t TWO_0X   = '{mask: 8'hF8, value: 8'h08};
  localparam opc_pat_t TWO_3X   = '{mask: 8'hF8, value: 8'h30};
  localparam opc_pat_t TWO_5X   = '{mask: 8'hF8, value: 8'h58};

  localparam opc_pat_t CTRL_03  = '{mask: 8'hFF, value: 8'h03};
  localparam opc_pat_t CTRL_04  = '{mask: 8'hFC, value: 8'h04};
  localparam opc_pat_t CTRL_0X  = '{mask: 8'hF8, value: 8'h08};
  localparam opc_pat_t CTRL_2X  = '{mask: 8'hF8, value: 8'h28};
  localparam opc_pat_t CTRL_3X  = '{mask: 8'hF0, value: 8'h30};
  localparam opc_pat_t CTRL_4X  = '{mask: 8'hF8, value: 8'h48};

  localparam opc_pat_t MEMRD_07 = '{mask: 8'hFF, value: 8'h07};
  localparam opc_pat_t MEMRD_4X = '{mask: 8'hF8, value: 8'h48};
  localparam opc_pat_t MEMRD_7X = '{mask: 8'hF0, value: 8'h70};

  function automatic logic pat_hit(input logic [7:0] opc, input opc_pat_t p);
    return (opc & p.mask) == p.value;
  endfunction

  function automatic opc_class_t classify(input logic [7:0] opc);
    opc_class_t c;
    // Immediate-operand ALU group: upper nibble 8..E with bit 3 set.
    c.is_two_byte = pat_hit(opc, TWO_03) | pat_hit(opc, TWO_05)
                  | pat_hit(opc, TWO_0X) | pat_hit(opc, TWO_3X)
                  | pat_hit(opc, TWO_5X)
                  | (opc[7] & opc[3] & (opc[7:4] != 4'hF));
    c.is_ctrl     = pat_hit(opc, CTRL_03) | pat_hit(opc, CTRL_04)
                  | pat_hit(opc, CTRL_0X) | pat_hit(opc, CTRL_2X)
                  | pat_hit(opc, CTRL_3X) | pat_hit(opc, CTRL_4X);
    c.is_memrd    = pat_hit(opc, MEMRD_07) | pat_hit(opc, MEMRD_4X)
                  | (pat_hit(opc, MEMRD_7X) & (opc != 8'h70));
    return c;
  endfunction

endpackage

// File: rtl/pipe_issue_ctrl_if.sv
// Fetch-buffer and issue-stage signals of the RNBIP issue controller.
interface pipe_issue_ctrl_if;
  logic       ib_valid;
  logic [7:0] ib_data;
  logic       ib_ready;
  logic       ex_stall;
  logic [7:0] opcode_out;
  logic [7:0] od_out;
  logic       id_valid;
  logic       flush;

  modport master (
    output ib_valid, ib_data, ex_stall,
    input  ib_ready, opcode_out, od_out, id_valid, flush
  );

  modport slave (
    input  ib_valid, ib_data, ex_stall,
    output ib_ready, opcode_out, od_out, id_valid, flush
  );
endinterface

// File: rtl/opcode_class.sv
// Combinational opcode decoder: two-byte, control-transfer and memory-read
// class flags for one opcode byte.
module opcode_class
  import rnbip_pkg::*;
(
  input  logic [7:0] opc,
  output opc_class_t cls
);
  always_comb begin
    cls = classify(opc);
  end
endmodule

// File: rtl/pipe_issue_ctrl.sv
// RNBIP issue sequencer: assembles one/two-byte instructions, inserts load
// bubbles and flush windows, and drives registered issue outputs.
module pipe_issue_ctrl
  import rnbip_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  pipe_issue_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] BUBBLE_LOAD = CNT_W'(LOAD_BUBBLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       latch_q, latch_d;
  issue_t           issue_q, issue_d;
  opc_class_t       cls;
  logic [7:0]       cls_in;
  logic             ready;
  logic             take;

  assign ready  = !bus.ex_stall && (state_q != ST_BUBBLE);
  assign take   = bus.ib_valid && ready;
  // In OPD the decision depends on the held opcode, not the operand byte.
  assign cls_in = (state_q == ST_OPD) ? latch_q : bus.ib_data;

  opcode_class u_class (
    .opc (cls_in),
    .cls (cls)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    issue_d = ISSUE_NONE;

    if (bus.ex_stall) begin
      issue_d = issue_q;
    end else begin
      unique case (state_q)
        ST_OPC: begin
          if (take) begin
            if (cls.is_two_byte) begin
              latch_d = bus.ib_data;
              state_d = ST_OPD;
            end else begin
              issue_d = '{opcode: bus.ib_data, od: NOP_OPC, valid: 1'b1};
              if (cls.is_ctrl) begin
                if (FLUSH_CYCLES != 0) begin
                  state_d = ST_FLUSH;
                  cnt_d   = FLUSH_LOAD;
                end
              end else if (cls.is_memrd && (LOAD_BUBBLES != 0)) begin
                state_d = ST_BUBBLE;
                cnt_d   = BUBBLE_LOAD;
              end
            end
          end
        end

        ST_OPD: begin
          if (take) begin
            issue_d = '{opcode: latch_q, od: bus.ib_data, valid: 1'b1};
            state_d = ST_OPC;
            if (cls.is_ctrl && (FLUSH_CYCLES != 0)) begin
              state_d = ST_FLUSH;
              cnt_d   = FLUSH_LOAD;
            end
          end
        end

        ST_FLUSH, ST_BUBBLE: begin
          // Bytes taken while flushing are simply dropped.
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_OPC;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_OPC;
      cnt_q   <= '0;
      latch_q <= NOP_OPC;
      issue_q <= ISSUE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      issue_q <= issue_d;
    end
  end

  assign bus.ib_ready   = ready;
  assign bus.flush      = (state_q == ST_FLUSH);
  assign bus.opcode_out = issue_q.opcode;
  assign bus.od_out     = issue_q.od;
  assign bus.id_valid   = issue_q.valid;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench: directed and random streams into two controller
// configurations, compared each cycle against an abstract issue model.
module tb_pipe_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_issue_ctrl_if bus_a ();
  pipe_issue_ctrl_if bus_b ();

  pipe_issue_ctrl #(.FLUSH_CYCLES(2), .LOAD_BUBBLES(1), .CNT_W(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipe_issue_ctrl #(.FLUSH_CYCLES(0), .LOAD_BUBBLES(0), .CNT_W(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Abstract model: a pending-opcode flag plus "cycles left" windows.
  typedef struct {
    bit         pend;
    logic [7:0] pend_opc;
    int         flush_left;
    int         bubble_left;
    logic [7:0] opc;
    logic [7:0] od;
    logic [7:0] vld;
  } model_t;

  model_t m_a, m_b;

  function automatic bit tb_two(input logic [7:0] d);
    int v  = int'(d);
    int hi = v / 16;
    int lo = v % 16;
    return v == 3 || v == 5 || (v >= 8 && v <= 15) || (v >= 48 && v <= 55) ||
           (v >= 88 && v <= 95) || (hi >= 8 && hi <= 14 && lo >= 8);
  endfunction

  function automatic bit tb_ctrl(input logic [7:0] d);
    int v = int'(d);
    return (v >= 3 && v <= 15) || (v >= 40 && v <= 63) || (v >= 72 && v <= 79);
  endfunction

  function automatic bit tb_memrd(input logic [7:0] d);
    int v = int'(d);
    return v == 7 || (v >= 72 && v <= 79) || (v >= 113 && v <= 127);
  endfunction

  function automatic model_t model_reset();
    model_t n;
    n.pend = 1'b0; n.pend_opc = 8'h00; n.flush_left = 0; n.bubble_left = 0;
    n.opc = 8'h00; n.od = 8'h00; n.vld = 8'h00;
    return n;
  endfunction

  function automatic bit model_ready(input model_t s, input bit stall);
    return !stall && s.bubble_left == 0;
  endfunction

  function automatic model_t model_next(input model_t s, input bit r, input bit stall,
                                        input bit valid, input logic [7:0] d,
                                        input int fl, input int bl);
    model_t n = s;
    bit take;
    if (r) return model_reset();
    if (stall) return s;
    take  = valid && model_ready(s, stall);
    n.opc = 8'h00; n.od = 8'h00; n.vld = 8'h00;
    if (s.bubble_left > 0) begin
      n.bubble_left = s.bubble_left - 1;
    end else if (s.flush_left > 0) begin
      n.flush_left = s.flush_left - 1;
    end else if (s.pend) begin
      if (take) begin
        n.opc = s.pend_opc; n.od = d; n.vld = 8'h01; n.pend = 1'b0;
        if (tb_ctrl(s.pend_opc)) n.flush_left = fl;
      end
    end else if (take) begin
      if (tb_two(d)) begin
        n.pend = 1'b1; n.pend_opc = d;
      end else begin
        n.opc = d; n.vld = 8'h01;
        if (tb_ctrl(d)) n.flush_left = fl;
        else if (tb_memrd(d)) n.bubble_left = bl;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs after the falling edge, check, then advance models.
  task automatic cycle(input bit r, input bit stall, input bit valid, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    bus_a.ex_stall = stall; bus_a.ib_valid = valid; bus_a.ib_data = d;
    bus_b.ex_stall = stall; bus_b.ib_valid = valid; bus_b.ib_data = d;
    #1;
    check("a_opcode", bus_a.opcode_out, m_a.opc);
    check("a_od",     bus_a.od_out,     m_a.od);
    check("a_valid",  8'(bus_a.id_valid), m_a.vld);
    check("a_flush",  8'(bus_a.flush),    8'(m_a.flush_left > 0));
    check("a_ready",  8'(bus_a.ib_ready), 8'(model_ready(m_a, stall)));
    check("b_opcode", bus_b.opcode_out, m_b.opc);
    check("b_od",     bus_b.od_out,     m_b.od);
    check("b_valid",  8'(bus_b.id_valid), m_b.vld);
    check("b_flush",  8'(bus_b.flush),    8'(m_b.flush_left > 0));
    check("b_ready",  8'(bus_b.ib_ready), 8'(model_ready(m_b, stall)));
    @(posedge clk);
    m_a = model_next(m_a, r, stall, valid, d, 2, 1);
    m_b = model_next(m_b, r, stall, valid, d, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.ex_stall = 1'b0; bus_a.ib_valid = 1'b0; bus_a.ib_data = 8'h00;
    bus_b.ex_stall = 1'b0; bus_b.ib_valid = 1'b0; bus_b.ib_data = 8'h00;
    @(posedge clk);
    m_a = model_reset();
    m_b = model_reset();

    // Reset state, then a one-byte/two-byte mix ending in JCD 09 + operand.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h81);
    cycle(1'b0, 1'b0, 1'b1, 8'h40);
    cycle(1'b0, 1'b0, 1'b1, 8'h09);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h33);
    idle(4);

    // JUA then three bytes: two fall into the flush window.
    cycle(1'b0, 1'b0, 1'b1, 8'h04);
    cycle(1'b0, 1'b0, 1'b1, 8'hA0);
    cycle(1'b0, 1'b0, 1'b1, 8'hA1);
    cycle(1'b0, 1'b0, 1'b1, 8'hA2);
    idle(2);

    // LDA R1 followed by a byte held through the load bubble.
    cycle(1'b0, 1'b0, 1'b1, 8'h71);
    cycle(1'b0, 1'b0, 1'b1, 8'h02);
    cycle(1'b0, 1'b0, 1'b1, 8'h02);
    idle(2);

    // Stall holding an issued instruction, then stall inside a flush window.
    cycle(1'b0, 1'b0, 1'b1, 8'h42);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 8'h99);
    idle(1);
    cycle(1'b0, 1'b0, 1'b1, 8'h04);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 8'h55);
    cycle(1'b0, 1'b0, 1'b1, 8'h55);
    cycle(1'b0, 1'b0, 1'b1, 8'h56);
    cycle(1'b0, 1'b0, 1'b1, 8'h57);
    idle(2);

    // Reset while waiting for an operand drops the latched opcode.
    cycle(1'b0, 1'b0, 1'b1, 8'h89);
    cycle(1'b1, 1'b0, 1'b1, 8'h12);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    idle(2);

    // RTU followed immediately by another byte.
    cycle(1'b0, 1'b0, 1'b1, 8'h07);
    cycle(1'b0, 1'b0, 1'b1, 8'h10);
    idle(4);

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 9) < 7, 8'($urandom));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
